// File: rtl/otter_pc_pkg.sv
// otter_pc_pkg: shared state encoding and constants for the OTTER PC controller
package otter_pc_pkg;
  typedef enum logic [1:0] {INIT, FETCH, EXEC, TRAP} pc_state_t;
  localparam logic [1:0]  CAUSE_INTR      = 2'b01;
  localparam logic [1:0]  CAUSE_MISALIGN  = 2'b10;
  localparam logic [1:0]  CAUSE_FETCH_TMO = 2'b11;
  localparam logic [31:0] PC_INCR         = 32'd4;
endpackage

// File: rtl/otter_pc_next_sel.sv
// otter_pc_next_sel: next-PC priority mux (MRET > branch > PC+4) with misalignment flag
module otter_pc_next_sel
  import otter_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        mret,
  input  logic [31:0] mepc,
  output logic [31:0] next_pc,
  output logic        misalign
);
  always_comb begin
    next_pc  = mret ? mepc : br_taken ? br_target : pc + PC_INCR;
    misalign = |next_pc[1:0];
  end
endmodule

// File: rtl/otter_pc_ctrl.sv
// otter_pc_ctrl: fetch/execute/trap sequencer driving the OTTER PC register
// Define OTTER_PC_RETIRE_CNT_EN to add the 64-bit RETIRE_CNT output.
module otter_pc_ctrl
  import otter_pc_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [31:0] PC_COUNT,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  output logic        IR_VALID,
  input  logic        EXEC_DONE,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        MRET,
  input  logic [31:0] MEPC,
  input  logic [31:0] MTVEC,
  input  logic        INTR,
  input  logic        INT_EN,
  output logic [31:0] PC_DIN,
  output logic        PC_WE,
  output logic        PC_CLR,
  output logic        TRAP_TAKEN,
  output logic [1:0]  TRAP_CAUSE,
  output logic [31:0] TRAP_EPC
`ifdef OTTER_PC_RETIRE_CNT_EN
  ,
  output logic [63:0] RETIRE_CNT
`endif
);
  localparam int TMO_W = IMEM_TIMEOUT > 0 ? $clog2(IMEM_TIMEOUT + 1) : 1;
  // Trap fires in the cycle the counter shows IMEM_TIMEOUT-1, so REQ stays high exactly IMEM_TIMEOUT cycles
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IMEM_TIMEOUT - 1);
  pc_state_t state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0] next_pc;
  logic misalign, done, tmo, unused_ok;
  otter_pc_next_sel u_next_sel (
    .pc(PC_COUNT),
    .br_taken(BR_TAKEN),
    .br_target(BR_TARGET),
    .mret(MRET),
    .mepc(MEPC),
    .next_pc(next_pc),
    .misalign(misalign)
  );
  assign unused_ok  = ^MTVEC[1:0];
  assign done       = state == EXEC && EXEC_DONE;
  assign tmo        = IMEM_TIMEOUT != 0 && !IMEM_ACK && tmo_cnt == TMO_LAST;
  assign IMEM_REQ   = state == FETCH;
  assign IR_VALID   = IMEM_REQ && IMEM_ACK;
  assign PC_CLR     = state == INIT;
  assign TRAP_TAKEN = state == TRAP;
  assign PC_WE      = TRAP_TAKEN || (done && !misalign);
  assign PC_DIN     = TRAP_TAKEN ? {MTVEC[31:2], 2'b00} : PC_WE ? next_pc : '0;
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state      <= INIT;
      tmo_cnt    <= '0;
      TRAP_CAUSE <= '0;
      TRAP_EPC   <= '0;
    end else begin
      case (state)
        INIT: state <= FETCH;
        FETCH:
          if (IMEM_ACK) begin
            tmo_cnt <= '0;
            state   <= EXEC;
          end else if (tmo) begin
            tmo_cnt    <= '0;
            TRAP_CAUSE <= CAUSE_FETCH_TMO;
            TRAP_EPC   <= PC_COUNT;
            state      <= TRAP;
          end else tmo_cnt <= tmo_cnt + TMO_W'(1);
        EXEC:
          if (EXEC_DONE) begin
            if (misalign) begin
              TRAP_CAUSE <= CAUSE_MISALIGN;
              TRAP_EPC   <= PC_COUNT;
              state      <= TRAP;
            end else if (INTR && INT_EN) begin
              TRAP_CAUSE <= CAUSE_INTR;
              TRAP_EPC   <= next_pc;
              state      <= TRAP;
            end else state <= FETCH;
          end
        TRAP: state <= FETCH;
        default: state <= INIT;
      endcase
    end
  end
`ifdef OTTER_PC_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) RETIRE_CNT <= '0;
    else if (done && !misalign) RETIRE_CNT <= RETIRE_CNT + 64'd1;
  end
`endif
endmodule
